// File: rtl/addsub_flags_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : addsub_flags_pipe_if
// Brief    : Operand/result handshake bundle for addsub_flags_pipe.
//            ADDSUB_SAT_EN adds the in_sat beat qualifier.
// Revision : 1.0 - initial release
// ============================================================================
interface addsub_flags_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_setf;
`ifdef ADDSUB_SAT_EN
  logic             in_sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [3:0]       out_nzcv;
  logic [3:0]       flags;

`ifdef ADDSUB_SAT_EN
  modport master (
    output in_valid, in_a, in_b, in_op, in_setf, in_sat, out_ready,
    input  in_ready, out_valid, out_res, out_nzcv, flags
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_setf, in_sat, out_ready,
    output in_ready, out_valid, out_res, out_nzcv, flags
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_op, in_setf, out_ready,
    input  in_ready, out_valid, out_res, out_nzcv, flags
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_setf, out_ready,
    output in_ready, out_valid, out_res, out_nzcv, flags
  );
`endif
endinterface
`default_nettype wire

// File: rtl/addsub_flags_pipe.sv
`default_nettype none
// ============================================================================
// Module   : addsub_flags_pipe
// Brief    : 2-stage ADD/SUB/ADC/SBC unit with NZCV flags and a chained
//            flag register. ADDSUB_SAT_EN enables signed saturation.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_flags_pipe #(
  parameter int WIDTH = 32
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  addsub_flags_pipe_if.slave bus
);
  localparam int         MSB    = WIDTH - 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic             s1_setf_q, s1_setf_d;
  logic             s1_sat_q, s1_sat_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic [3:0]       flags_q, flags_d;

  logic             s2_adv;
  logic             in_ready;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw_res;
  logic [WIDTH-1:0] fin_res;
  logic             c_flag;
  logic             v_flag;

  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  // Carry-in comes straight from the flag register so a chained op that
  // follows a setf op on the very next edge already sees the fresh carry.
  always_comb begin
    b_eff = s1_b_q;
    cin   = 1'b0;
    case (s1_op_q)
      OP_ADD: begin b_eff = s1_b_q;  cin = 1'b0;       end
      OP_SUB: begin b_eff = ~s1_b_q; cin = 1'b1;       end
      OP_ADC: begin b_eff = s1_b_q;  cin = flags_q[1]; end
      OP_SBC: begin b_eff = ~s1_b_q; cin = flags_q[1]; end
    endcase
  end

  always_comb begin
    sum     = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    raw_res = sum[WIDTH-1:0];
    c_flag  = sum[WIDTH];
    v_flag  = (s1_a_q[MSB] == b_eff[MSB]) && (raw_res[MSB] != s1_a_q[MSB]);
    fin_res = raw_res;
`ifdef ADDSUB_SAT_EN
    // Overflowed result has the wrong sign, so clamp toward the opposite one.
    if (s1_sat_q && v_flag) begin
      fin_res = raw_res[MSB] ? {1'b0, {(WIDTH-1){1'b1}}}
                             : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_setf_d  = s1_setf_q;
    s1_sat_d   = s1_sat_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d    = bus.in_a;
        s1_b_d    = bus.in_b;
        s1_op_d   = bus.in_op;
        s1_setf_d = bus.in_setf;
`ifdef ADDSUB_SAT_EN
        s1_sat_d  = bus.in_sat;
`else
        s1_sat_d  = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    nzcv_d     = nzcv_q;
    flags_d    = flags_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d  = fin_res;
        nzcv_d = {fin_res[MSB], (fin_res == '0), c_flag, v_flag};
        if (s1_setf_q) begin
          flags_d = {fin_res[MSB], (fin_res == '0), c_flag, v_flag};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ADD;
      s1_setf_q  <= 1'b0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      nzcv_q     <= 4'b0000;
      flags_q    <= 4'b0000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_setf_q  <= s1_setf_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      nzcv_q     <= nzcv_d;
      flags_q    <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_res   = res_q;
  assign bus.out_nzcv  = nzcv_q;
  assign bus.flags     = flags_q;

endmodule
`default_nettype wire
